fir_ctrl: RTL and testbench

FIR_CTRL -- requirements
Module: fir_ctrl

---
 rtl/fir_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fir_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// fir_ctrl: AXI-Lite register/tap front-end and run control for the FIR engine.
// Holds ap_ctrl, data_length and tap_num, and arbitrates the tap BRAM port.
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   eng_start,
  input  logic                   eng_done,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [31:0]            data_length,
  output logic [5:0]             tap_num,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(16'h10);
  localparam logic [pADDR_WIDTH-1:0] A_TAPN = pADDR_WIDTH'(16'h14);
  localparam int                     ZPAD   = pADDR_WIDTH - 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;

  logic                   awready_q, arready_q, eng_start_q;
  logic                   rvalid_q, rd_busy_q, rd_p1_q;
  logic                   rd_tap_q, rd_cap_q, rd_ctrl_q;
  logic [6:0]             rd_a_q;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [31:0]            data_length_q;
  logic [5:0]             tap_num_q;

  logic                   aw_tap, ar_tap, wr_acc, ar_acc;
  logic                   aw_set, ar_set, go, cfg_wr;
  logic [5:0]             tap_num_w;
  logic [pDATA_WIDTH-1:0] rd_val;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a[pADDR_WIDTH-1:8] == '0) && a[7];
  endfunction

  assign aw_tap = is_tap(awaddr);
  assign ar_tap = is_tap(araddr);
  assign wr_acc = awready_q & awvalid & wvalid;
  assign ar_acc = arready_q & arvalid;
  // a tap write may not land in the address cycle of an accepted tap read
  assign aw_set = awvalid & wvalid & ~awready_q
                & ~(arready_q & ar_tap & aw_tap);
  // on a same-cycle tap write/read, the write goes first
  assign ar_set = arvalid & ~arready_q & ~rd_busy_q
                & ~(aw_set & aw_tap & ar_tap);
  assign go     = wr_acc & (awaddr == A_CTRL) & wdata[0]
                & (state_q == IDLE);
  assign cfg_wr = wr_acc & (state_q == IDLE);

  // tap_num clamp: 0 -> 1, above 32 -> 32
  always_comb begin
    tap_num_w = wdata[5:0];
    if (wdata == '0) tap_num_w = 6'd1;
    else if (wdata > pDATA_WIDTH'(32)) tap_num_w = 6'd32;
  end

  // read data mux, sampled at read acceptance
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      araddr == A_CTRL: rd_val = {{(pDATA_WIDTH-3){1'b0}},
                                  state_q == IDLE,
                                  state_q == DONE,
                                  eng_start_q};
      araddr == A_LEN:  rd_val = pDATA_WIDTH'(data_length_q);
      araddr == A_TAPN: rd_val = pDATA_WIDTH'(tap_num_q);
      ar_tap:           rd_val = (state_q == RUN) ? '1 : '0;
      default:          rd_val = '0;
    endcase
  end

  // main FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (eng_done) state_d = DONE;
      DONE:    if (rvalid_q & rready & rd_ctrl_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, handshake pulses and config registers
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q       <= IDLE;
      awready_q     <= 1'b0;
      arready_q     <= 1'b0;
      eng_start_q   <= 1'b0;
      data_length_q <= '0;
      tap_num_q     <= 6'd1;
    end else begin
      state_q     <= state_d;
      awready_q   <= aw_set;
      arready_q   <= ar_set;
      eng_start_q <= go;
      if (cfg_wr && awaddr == A_LEN) data_length_q <= 32'(wdata);
      if (cfg_wr && awaddr == A_TAPN) tap_num_q <= tap_num_w;
    end
  end

  // read pipeline: accept, address BRAM, present data, hold for rready
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rd_busy_q <= 1'b0;
      rd_p1_q   <= 1'b0;
      rd_tap_q  <= 1'b0;
      rd_cap_q  <= 1'b0;
      rd_ctrl_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_a_q    <= '0;
      rdata_q   <= '0;
    end else begin
      rd_p1_q  <= ar_acc;
      rd_cap_q <= rd_p1_q & rd_tap_q;
      if (ar_acc) begin
        rd_busy_q <= 1'b1;
        rd_tap_q  <= ar_tap & (state_q != RUN);
        rd_ctrl_q <= araddr == A_CTRL;
        rd_a_q    <= araddr[6:0];
        rdata_q   <= rd_val;
      end
      if (rd_p1_q) rvalid_q <= 1'b1;
      if (rd_cap_q) rdata_q <= tap_Do;
      if (rvalid_q && rready) begin
        rvalid_q  <= 1'b0;
        rd_busy_q <= 1'b0;
      end
    end
  end

  // tap BRAM port: engine owns it in RUN, else AXI write, else AXI read
  always_comb begin
    tap_A  = '0;
    tap_WE = 4'h0;
    tap_Di = '0;
    if (state_q == RUN) begin
      tap_A = eng_tap_A;
    end else if (wr_acc && aw_tap) begin
      tap_A  = {{ZPAD{1'b0}}, awaddr[6:0]};
      tap_WE = 4'hF;
      tap_Di = wdata;
    end else if (rd_p1_q && rd_tap_q) begin
      tap_A = {{ZPAD{1'b0}}, rd_a_q};
    end
  end

  assign tap_EN      = 1'b1;
  assign awready     = awready_q;
  assign wready      = awready_q;
  assign arready     = arready_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rd_cap_q ? tap_Do : rdata_q;
  assign eng_start   = eng_start_q;
  assign data_length = data_length_q;
  assign tap_num     = tap_num_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed + randomized bench for fir_ctrl with a behavioural
// register/run model and a 1-cycle-latency tap BRAM.
module tb_fir_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        rready = 1'b0, eng_done = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0, eng_tap_A = '0;
  logic [31:0] wdata = '0, tap_Do = '0;
  logic        awready, wready, arready, rvalid, eng_start, tap_EN;
  logic [31:0] rdata, tap_Di, data_length;
  logic [5:0]  tap_num;
  logic [3:0]  tap_WE;
  logic [11:0] tap_A;

  logic [31:0] mem [0:31];

  int n_run = 0;
  int n_fail = 0;

  bit          m_run, m_done;
  logic [31:0] m_len;
  int          m_tapn;
  logic [31:0] m_coef [0:31];

  always #5 clk = ~clk;

  fir_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .eng_start(eng_start), .eng_done(eng_done), .eng_tap_A(eng_tap_A),
    .data_length(data_length), .tap_num(tap_num),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di),
    .tap_A(tap_A), .tap_Do(tap_Do)
  );

  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[6:2]] <= tap_Di;
      tap_Do <= mem[tap_A[6:2]];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit m_is_tap(input logic [11:0] a);
    return a >= 12'h080 && a <= 12'h0FF;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h000) return {29'b0, !m_run && !m_done, m_done, 1'b0};
    if (a == 12'h010) return m_len;
    if (a == 12'h014) return 32'(m_tapn);
    if (m_is_tap(a)) return m_run ? 32'hFFFF_FFFF : m_coef[(int'(a) - 128) / 4];
    return 32'h0;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d);
    bool_busy: begin
      if (a == 12'h000) begin
        if (d[0] && !m_run && !m_done) m_run = 1;
      end else if (!m_run && !m_done) begin
        if (a == 12'h010) m_len = d;
        else if (a == 12'h014) m_tapn = (d == 0) ? 1 : (d > 32) ? 32 : int'(d);
        else if (m_is_tap(a)) m_coef[(int'(a) - 128) / 4] = d;
      end
    end
  endtask

  task automatic m_engdone();
    if (m_run) begin
      m_run = 0;
      m_done = 1;
    end
  endtask

  task automatic m_reset();
    m_run = 0;
    m_done = 0;
    m_len = 0;
    m_tapn = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ready"},
          {27'b0, awready, wready, arready, rvalid, eng_start}, 32'h0);
    check({tag, "_tap_WE"}, {28'b0, tap_WE}, 32'h0);
    chk1({tag, "_tap_EN"}, tap_EN, 1'b1);
    check({tag, "_tap_A"}, {20'b0, tap_A}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_data_length"}, data_length, 32'h0);
    check({tag, "_tap_num"}, {26'b0, tap_num}, 32'd1);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           output logic [3:0] we, output logic [11:0] ta);
    awaddr = a;
    wdata = d;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !awready; i++) @(negedge clk);
    chk1("wr_accept", awready & wready, 1'b1);
    we = tap_WE;
    ta = tap_A;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("wr_ready_drop", {30'b0, awready, wready}, 32'h0);
    m_write(a, d);
  endtask

  task automatic axi_read(input logic [11:0] a, input bit pulse_done,
                          output logic [31:0] d, output int lat);
    logic [31:0] first;
    bit stable;
    d = '0;
    lat = -1;
    araddr = a;
    arvalid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !arready; i++) @(negedge clk);
    chk1("rd_accept", arready, 1'b1);
    if (!arready) begin
      arvalid = 1'b0;
      return;
    end
    if (pulse_done) eng_done = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    eng_done = 1'b0;
    if (pulse_done) m_engdone();
    lat = 1;
    for (int i = 0; i < 50 && !rvalid; i++) begin
      @(negedge clk);
      lat++;
    end
    chk1("rvalid_seen", rvalid, 1'b1);
    if (!rvalid) return;
    first = rdata;
    stable = 1;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      if (rdata !== first || !rvalid) stable = 0;
    end
    chk1("rd_hold", stable, 1'b1);
    rready = 1'b1;
    d = first;
    @(negedge clk);
    rready = 1'b0;
    chk1("rvalid_drop", rvalid, 1'b0);
    if (a == 12'h000 && m_done) m_done = 0;
  endtask

  task automatic rd_chk(input logic [11:0] a, input string tag);
    logic [31:0] e, d;
    int lat;
    e = m_read(a);
    axi_read(a, 1'b0, d, lat);
    check(tag, d, e);
    check({tag, "_lat"}, lat, 32'd2);
  endtask

  logic [3:0]  we, we2;
  logic [11:0] ta, ta2;
  logic [31:0] v, e, d;
  int          lat;
  bit          bad;
  int          coefs [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    m_reset();
    for (int i = 0; i < 32; i++) m_coef[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;
    @(negedge clk);

    axi_write(12'h010, 32'd600, we, ta);
    axi_write(12'h014, 32'd11, we, ta);
    rd_chk(12'h010, "len600");
    rd_chk(12'h014, "tapn11");
    check("data_length_o", data_length, m_len);
    check("tap_num_o", {26'b0, tap_num}, 32'(m_tapn));
    for (int k = 0; k < 4; k++) begin
      axi_write(12'h010, $urandom, we, ta);
      rd_chk(12'h010, "len_rnd");
      axi_write(12'h014, 32'($urandom_range(1, 32)), we, ta);
      rd_chk(12'h014, "tapn_rnd");
    end
    rd_chk(12'h000, "ctrl_idle");
    rd_chk(12'h020, "unmapped20");
    rd_chk(12'h100, "unmapped100");

    for (int i = 0; i < 11; i++) begin
      axi_write(12'h080 + 12'(4 * i), 32'(coefs[i]), we, ta);
      check("tap_wr_WE", {28'b0, we}, 32'hF);
      check("tap_wr_A", {20'b0, ta}, 32'(4 * i));
    end
    for (int i = 11; i < 16; i++)
      axi_write(12'h080 + 12'(4 * i), $urandom, we, ta);
    for (int i = 0; i < 16; i++) rd_chk(12'h080 + 12'(4 * i), "tap_rd");

    v = $urandom;
    fork
      axi_write(12'h090, v, we2, ta2);
      axi_read(12'h090, 1'b0, d, lat);
    join
    check("collide_we", {28'b0, we2}, 32'hF);
    check("collide_rd", d, m_coef[4]);
    check("collide_lat", lat, 32'd2);

    axi_write(12'h000, 32'd1, we, ta);
    chk1("eng_start_pulse", eng_start, 1'b1);
    @(negedge clk);
    chk1("eng_start_end", eng_start, 1'b0);
    eng_tap_A = {5'b0, 5'($urandom_range(0, 31)), 2'b0};
    #1;
    check("run_tap_A", {20'b0, tap_A}, {20'b0, eng_tap_A});
    check("run_tap_WE", {28'b0, tap_WE}, 32'h0);
    rd_chk(12'h000, "ctrl_run");
    axi_write(12'h084, 32'd7, we, ta);
    check("run_wr_WE", {28'b0, we}, 32'h0);
    rd_chk(12'h084, "tap_rd_run");
    axi_write(12'h010, $urandom, we, ta);
    rd_chk(12'h010, "len_run_discard");
    axi_write(12'h014, 32'd5, we, ta);
    rd_chk(12'h014, "tapn_run_discard");
    axi_write(12'h000, 32'd1, we, ta);
    chk1("restart_in_run", eng_start, 1'b0);

    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    m_engdone();
    rd_chk(12'h000, "ctrl_done");
    rd_chk(12'h000, "ctrl_after_done");
    rd_chk(12'h084, "tap_kept");
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    m_engdone();
    rd_chk(12'h000, "done_in_idle");

    axi_write(12'h014, 32'd40, we, ta);
    rd_chk(12'h014, "tapn_40");
    axi_write(12'h014, 32'd0, we, ta);
    rd_chk(12'h014, "tapn_0");
    axi_write(12'h014, 32'($urandom_range(33, 100000)), we, ta);
    rd_chk(12'h014, "tapn_big");
    axi_write(12'h014, 32'd32, we, ta);
    rd_chk(12'h014, "tapn_32");

    axi_write(12'h000, 32'd1, we, ta);
    e = m_read(12'h000);
    axi_read(12'h000, 1'b1, d, lat);
    check("ctrl_done_coincident", d, e);
    check("ctrl_done_coincident_lat", lat, 32'd2);
    rd_chk(12'h000, "ctrl_after_coincident");

    axi_write(12'h000, 32'd1, we, ta);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_reset("rst_run");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (eng_start || rvalid) bad = 1;
    end
    chk1("quiet_after_rst", bad, 1'b0);
    rd_chk(12'h000, "ctrl_after_rst");
    rd_chk(12'h010, "len_after_rst");
    rd_chk(12'h014, "tapn_after_rst");
    rd_chk(12'h084, "tap_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
